// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller: sits downstream of the traffic-light FSM.
// It synchronises the lamp signals and a raw push-button, debounces and
// latches requests, and grants a timed WALK / flashing DON'T-WALK window at
// the start of a red phase. Any abort or illegal lamp code forces DON'T-WALK.
module ped_crossing_ctrl #(
  parameter int DEB_CYCLES  = 16,
  parameter int DEB_W       = 5,
  parameter int WALK_TICKS  = 4,
  parameter int FLASH_TICKS = 4,
  parameter int CW          = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic          red,
  input  logic          yellow,
  input  logic          green,
  input  logic          btn,
  output logic          walk,
  output logic          dont_walk,
  output logic          flash,
  output logic          req_pending,
  output logic [CW-1:0] countdown,
  output logic          abort,
  output logic          lamp_fault
);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [CW-1:0]    WALK_L   = CW'(WALK_TICKS);
  localparam logic [CW-1:0]    FLASH_L  = CW'(FLASH_TICKS);
  localparam logic [CW-1:0]    WINDOW_L = CW'(WALK_TICKS + FLASH_TICKS);
  localparam logic [CW-1:0]    ONE_L    = CW'(1);

  typedef enum logic [1:0] {IDLE, WALK, FLASH, CLEAR} state_t;

  state_t           state;
  logic [CW-1:0]    tcnt;
  logic [1:0]       red_sy, yellow_sy, green_sy, btn_sy;
  logic             red_d;
  logic             ill_d;
  logic             btn_db, btn_db_d;
  logic [DEB_W-1:0] deb_cnt;

  logic red_s, yellow_s, green_s, btn_s;
  logic red_rise, lamp_legal, db_rise;

  assign red_s    = red_sy[1];
  assign yellow_s = yellow_sy[1];
  assign green_s  = green_sy[1];
  assign btn_s    = btn_sy[1];
  assign red_rise = red_s & ~red_d;
  // Odd parity with not all three set means exactly one lamp is lit.
  assign lamp_legal = (red_s ^ yellow_s ^ green_s) & ~(red_s & yellow_s & green_s);
  assign db_rise  = btn_db & ~btn_db_d;

  // Two-flop synchronisers for the asynchronous lamp and button inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red_sy    <= '0;
      yellow_sy <= '0;
      green_sy  <= '0;
      btn_sy    <= '0;
      red_d     <= 1'b0;
    end else begin
      red_sy    <= {red_sy[0], red};
      yellow_sy <= {yellow_sy[0], yellow};
      green_sy  <= {green_sy[0], green};
      btn_sy    <= {btn_sy[0], btn};
      red_d     <= red_s;
    end
  end

  // Lamp code check: a single illegal cycle is tolerated as transition skew.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ill_d      <= 1'b0;
      lamp_fault <= 1'b0;
    end else begin
      ill_d <= ~lamp_legal;
      if (lamp_legal)
        lamp_fault <= 1'b0;
      else if (ill_d)
        lamp_fault <= 1'b1;
    end
  end

  // Button debouncer: level follows btn_s only after a sustained mismatch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_db   <= 1'b0;
      btn_db_d <= 1'b0;
      deb_cnt  <= '0;
    end else begin
      btn_db_d <= btn_db;
      if (btn_s == btn_db) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        btn_db  <= btn_s;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  // Crossing FSM with registered lamp outputs and request latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tcnt        <= '0;
      walk        <= 1'b0;
      dont_walk   <= 1'b1;
      flash       <= 1'b0;
      countdown   <= '0;
      abort       <= 1'b0;
      req_pending <= 1'b0;
    end else begin
      abort <= 1'b0;
      if (db_rise)
        req_pending <= 1'b1;
      unique case (state)
        IDLE: begin
          walk      <= 1'b0;
          dont_walk <= 1'b1;
          flash     <= 1'b0;
          countdown <= '0;
          if (req_pending && red_rise && !lamp_fault) begin
            state     <= WALK;
            walk      <= 1'b1;
            dont_walk <= 1'b0;
            tcnt      <= WALK_L;
            countdown <= WINDOW_L;
            // A press landing on this very cycle is kept for a later phase.
            if (!db_rise)
              req_pending <= 1'b0;
          end
        end
        WALK: begin
          if (!red_s || lamp_fault) begin
            state     <= CLEAR;
            abort     <= 1'b1;
            walk      <= 1'b0;
            dont_walk <= 1'b1;
            flash     <= 1'b0;
            countdown <= '0;
          end else if (tick) begin
            countdown <= countdown - ONE_L;
            if (tcnt == ONE_L) begin
              state     <= FLASH;
              tcnt      <= FLASH_L;
              walk      <= 1'b0;
              flash     <= 1'b1;
              dont_walk <= 1'b1;
            end else begin
              tcnt <= tcnt - ONE_L;
            end
          end
        end
        FLASH: begin
          if (!red_s || lamp_fault) begin
            state     <= CLEAR;
            abort     <= 1'b1;
            walk      <= 1'b0;
            dont_walk <= 1'b1;
            flash     <= 1'b0;
            countdown <= '0;
          end else if (tick) begin
            countdown <= countdown - ONE_L;
            if (tcnt == ONE_L) begin
              state     <= CLEAR;
              flash     <= 1'b0;
              dont_walk <= 1'b1;
              countdown <= '0;
            end else begin
              tcnt      <= tcnt - ONE_L;
              dont_walk <= ~dont_walk;
            end
          end
        end
        CLEAR: begin
          walk      <= 1'b0;
          dont_walk <= 1'b1;
          flash     <= 1'b0;
          countdown <= '0;
          if (!red_s && !lamp_fault)
            state <= IDLE;
        end
        default: begin
          state     <= CLEAR;
          walk      <= 1'b0;
          dont_walk <= 1'b1;
          flash     <= 1'b0;
          countdown <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Directed bench for ped_crossing_ctrl: each task drives one scenario and
// checks the registered outputs one time unit after the rising clock edge.
module tb_ped_crossing_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       red = 1'b0;
  logic       yellow = 1'b0;
  logic       green = 1'b1;
  logic       btn = 1'b0;
  logic       walk, dont_walk, flash, req_pending, abort, lamp_fault;
  logic [3:0] countdown;

  int errors = 0;
  int checks = 0;

  ped_crossing_ctrl #(
    .DEB_CYCLES(16),
    .DEB_W(5),
    .WALK_TICKS(4),
    .FLASH_TICKS(4),
    .CW(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tick(tick),
    .red(red),
    .yellow(yellow),
    .green(green),
    .btn(btn),
    .walk(walk),
    .dont_walk(dont_walk),
    .flash(flash),
    .req_pending(req_pending),
    .countdown(countdown),
    .abort(abort),
    .lamp_fault(lamp_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  // Green -> yellow -> red; red is applied on return, no edge consumed after.
  task automatic to_red();
    green = 1'b0; yellow = 1'b1; red = 1'b0;
    repeat (3) step();
    yellow = 1'b0; red = 1'b1;
  endtask

  task automatic to_green();
    red = 1'b0; yellow = 1'b0; green = 1'b1;
    repeat (4) step();
  endtask

  // Clean press while green, long enough to register a request.
  task automatic press_green();
    btn = 1'b1;
    repeat (25) step();
    btn = 1'b0;
    repeat (20) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (walk !== 1'b0) begin errors++; $display("FAIL rst_walk: got %0b want 0", walk); end
    checks++; if (dont_walk !== 1'b1) begin errors++; $display("FAIL rst_dont_walk: got %0b want 1", dont_walk); end
    checks++; if (flash !== 1'b0) begin errors++; $display("FAIL rst_flash: got %0b want 0", flash); end
    checks++; if (req_pending !== 1'b0) begin errors++; $display("FAIL rst_req: got %0b want 0", req_pending); end
    checks++; if (countdown !== 4'd0) begin errors++; $display("FAIL rst_countdown: got %0d want 0", countdown); end
    checks++; if (abort !== 1'b0) begin errors++; $display("FAIL rst_abort: got %0b want 0", abort); end
    checks++; if (lamp_fault !== 1'b0) begin errors++; $display("FAIL rst_lamp_fault: got %0b want 0", lamp_fault); end
    rst_n = 1'b1;
    repeat (5) step();
    checks++; if (lamp_fault !== 1'b0) begin errors++; $display("FAIL post_rst_fault: got %0b want 0", lamp_fault); end
    checks++; if (dont_walk !== 1'b1) begin errors++; $display("FAIL post_rst_dw: got %0b want 1", dont_walk); end
  endtask

  task automatic test_basic_window();
    logic [7:0] e_walk, e_flash, e_dw;
    logic [3:0] e_cd [8];
    e_walk  = 8'b0000_0111;
    e_flash = 8'b0111_1000;
    e_dw    = 8'b1010_1000;
    e_cd    = '{4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    btn = 1'b1;
    repeat (18) step();
    checks++; if (req_pending !== 1'b0) begin errors++; $display("FAIL basic_req_early: got %0b want 0", req_pending); end
    step();
    checks++; if (req_pending !== 1'b1) begin errors++; $display("FAIL basic_req_latency: got %0b want 1", req_pending); end
    repeat (11) step();
    btn = 1'b0;
    repeat (20) step();
    checks++; if (req_pending !== 1'b1) begin errors++; $display("FAIL basic_req_hold: got %0b want 1", req_pending); end
    to_red();
    repeat (2) step();
    checks++; if (walk !== 1'b0) begin errors++; $display("FAIL basic_walk_early: got %0b want 0", walk); end
    step();
    checks++; if (walk !== 1'b1) begin errors++; $display("FAIL basic_walk_on: got %0b want 1", walk); end
    checks++; if (dont_walk !== 1'b0) begin errors++; $display("FAIL basic_dw_off: got %0b want 0", dont_walk); end
    checks++; if (countdown !== 4'd8) begin errors++; $display("FAIL basic_cd_load: got %0d want 8", countdown); end
    checks++; if (req_pending !== 1'b0) begin errors++; $display("FAIL basic_req_clear: got %0b want 0", req_pending); end
    for (int i = 0; i < 8; i++) begin
      step(); step();
      do_tick();
      checks++; if (walk !== e_walk[i]) begin errors++; $display("FAIL basic_walk_t%0d: got %0b want %0b", i + 1, walk, e_walk[i]); end
      checks++; if (flash !== e_flash[i]) begin errors++; $display("FAIL basic_flash_t%0d: got %0b want %0b", i + 1, flash, e_flash[i]); end
      checks++; if (dont_walk !== e_dw[i]) begin errors++; $display("FAIL basic_dw_t%0d: got %0b want %0b", i + 1, dont_walk, e_dw[i]); end
      checks++; if (countdown !== e_cd[i]) begin errors++; $display("FAIL basic_cd_t%0d: got %0d want %0d", i + 1, countdown, e_cd[i]); end
    end
    step(); step();
    checks++; if (countdown !== 4'd0) begin errors++; $display("FAIL basic_cd_clear: got %0d want 0", countdown); end
    checks++; if (abort !== 1'b0) begin errors++; $display("FAIL basic_no_abort: got %0b want 0", abort); end
    to_green();
    checks++; if (walk !== 1'b0) begin errors++; $display("FAIL basic_idle_walk: got %0b want 0", walk); end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 20; i++) begin
      btn = ~btn;
      repeat (3) step();
    end
    btn = 1'b0;
    repeat (25) step();
    checks++; if (req_pending !== 1'b0) begin errors++; $display("FAIL bounce_req: got %0b want 0", req_pending); end
    to_red();
    repeat (5) step();
    checks++; if (walk !== 1'b0) begin errors++; $display("FAIL bounce_walk: got %0b want 0", walk); end
    do_tick();
    checks++; if (dont_walk !== 1'b1) begin errors++; $display("FAIL bounce_dw: got %0b want 1", dont_walk); end
    to_green();
  endtask

  task automatic test_mid_red();
    to_red();
    repeat (5) step();
    btn = 1'b1;
    repeat (25) step();
    btn = 1'b0;
    checks++; if (req_pending !== 1'b1) begin errors++; $display("FAIL midred_req: got %0b want 1", req_pending); end
    checks++; if (walk !== 1'b0) begin errors++; $display("FAIL midred_no_walk: got %0b want 0", walk); end
    repeat (20) step();
    checks++; if (walk !== 1'b0) begin errors++; $display("FAIL midred_no_walk2: got %0b want 0", walk); end
    to_green();
    checks++; if (req_pending !== 1'b1) begin errors++; $display("FAIL midred_req_kept: got %0b want 1", req_pending); end
    to_red();
    repeat (3) step();
    checks++; if (walk !== 1'b1) begin errors++; $display("FAIL midred_next_walk: got %0b want 1", walk); end
    checks++; if (countdown !== 4'd8) begin errors++; $display("FAIL midred_cd: got %0d want 8", countdown); end
    repeat (8) do_tick();
    checks++; if (dont_walk !== 1'b1 || walk !== 1'b0 || flash !== 1'b0) begin errors++;
      $display("FAIL midred_end: walk=%0b dw=%0b flash=%0b want 0 1 0", walk, dont_walk, flash); end
    to_green();
  endtask

  task automatic test_early_red_fall();
    press_green();
    checks++; if (req_pending !== 1'b1) begin errors++; $display("FAIL early_req: got %0b want 1", req_pending); end
    to_red();
    repeat (3) step();
    repeat (2) do_tick();
    checks++; if (countdown !== 4'd6) begin errors++; $display("FAIL early_cd: got %0d want 6", countdown); end
    red = 1'b0; green = 1'b1;
    repeat (2) step();
    checks++; if (walk !== 1'b1 || abort !== 1'b0) begin errors++; $display("FAIL early_pre: walk=%0b abort=%0b want 1 0", walk, abort); end
    step();
    checks++; if (abort !== 1'b1) begin errors++; $display("FAIL early_abort: got %0b want 1", abort); end
    checks++; if (walk !== 1'b0 || dont_walk !== 1'b1) begin errors++; $display("FAIL early_lamps: walk=%0b dw=%0b want 0 1", walk, dont_walk); end
    checks++; if (countdown !== 4'd0) begin errors++; $display("FAIL early_cd0: got %0d want 0", countdown); end
    step();
    checks++; if (abort !== 1'b0) begin errors++; $display("FAIL early_abort_len: got %0b want 0", abort); end
    checks++; if (req_pending !== 1'b0) begin errors++; $display("FAIL early_req0: got %0b want 0", req_pending); end
    repeat (10) step();
    checks++; if (walk !== 1'b0) begin errors++; $display("FAIL early_stay: got %0b want 0", walk); end
  endtask

  task automatic test_lamp_fault();
    green = 1'b0; yellow = 1'b1;
    repeat (4) step();
    yellow = 1'b0;
    step();
    green = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (lamp_fault !== 1'b0) begin errors++; $display("FAIL skew_fault_%0d: got %0b want 0", i, lamp_fault); end
    end
    press_green();
    to_red();
    repeat (3) step();
    checks++; if (walk !== 1'b1) begin errors++; $display("FAIL fault_walk: got %0b want 1", walk); end
    green = 1'b1;
    repeat (3) step();
    checks++; if (lamp_fault !== 1'b0 || walk !== 1'b1) begin errors++; $display("FAIL fault_pre: fault=%0b walk=%0b want 0 1", lamp_fault, walk); end
    green = 1'b0;
    step();
    checks++; if (lamp_fault !== 1'b1) begin errors++; $display("FAIL fault_set: got %0b want 1", lamp_fault); end
    checks++; if (abort !== 1'b0) begin errors++; $display("FAIL fault_abort_early: got %0b want 0", abort); end
    step();
    checks++; if (abort !== 1'b1) begin errors++; $display("FAIL fault_abort: got %0b want 1", abort); end
    checks++; if (walk !== 1'b0 || dont_walk !== 1'b1 || countdown !== 4'd0) begin errors++;
      $display("FAIL fault_clear: walk=%0b dw=%0b cd=%0d want 0 1 0", walk, dont_walk, countdown); end
    step();
    checks++; if (abort !== 1'b0 || lamp_fault !== 1'b0) begin errors++; $display("FAIL fault_recover: abort=%0b fault=%0b want 0 0", abort, lamp_fault); end
    repeat (5) step();
    checks++; if (walk !== 1'b0) begin errors++; $display("FAIL fault_no_regrant: got %0b want 0", walk); end
    to_green();
    checks++; if (req_pending !== 1'b0) begin errors++; $display("FAIL fault_req: got %0b want 0", req_pending); end
  endtask

  task automatic test_async_reset();
    press_green();
    to_red();
    repeat (3) step();
    repeat (5) do_tick();
    checks++; if (flash !== 1'b1 || dont_walk !== 1'b0 || countdown !== 4'd3) begin errors++;
      $display("FAIL ares_pre: flash=%0b dw=%0b cd=%0d want 1 0 3", flash, dont_walk, countdown); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (walk !== 1'b0 || dont_walk !== 1'b1) begin errors++; $display("FAIL ares_lamps: walk=%0b dw=%0b want 0 1", walk, dont_walk); end
    checks++; if (flash !== 1'b0 || countdown !== 4'd0) begin errors++; $display("FAIL ares_flash: flash=%0b cd=%0d want 0 0", flash, countdown); end
    step();
    rst_n = 1'b1;
    repeat (5) step();
    checks++; if (walk !== 1'b0 || lamp_fault !== 1'b0) begin errors++; $display("FAIL ares_after: walk=%0b fault=%0b want 0 0", walk, lamp_fault); end
    to_green();
    press_green();
    to_red();
    repeat (3) step();
    checks++; if (walk !== 1'b1 || countdown !== 4'd8) begin errors++; $display("FAIL ares_idle_grant: walk=%0b cd=%0d want 1 8", walk, countdown); end
    to_green();
  endtask

  initial begin
    test_reset();
    test_basic_window();
    test_bounce();
    test_mid_red();
    test_early_red_fall();
    test_lamp_fault();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ped_crossing_ctrl.md
Name: ped_crossing_ctrl

Overview:
Pedestrian-signal stage that sits directly downstream of the traffic-light FSM and consumes its Red/Yellow/Green lamp outputs. It synchronises the lamp signals and a raw pedestrian push-button into a single clock domain, then debounces and latches pedestrian requests. It grants a timed WALK / flashing DON'T-WALK window only at the start of a red phase, and forces a safe DON'T-WALK on any abort or illegal lamp code.

Parameters:
DEB_CYCLES, 16, consecutive clk cycles the synchronised button must differ from the debounced level before that level changes
DEB_W, 5, debounce counter width (must hold DEB_CYCLES)
WALK_TICKS, 4, tick count of steady WALK (≥1)
FLASH_TICKS, 4, tick count of flashing DON'T-WALK (≥1)
CW, 4, countdown width (must hold WALK_TICKS+FLASH_TICKS)

Ports:
clk  in  1  single system clock
rst_n  in  1  asynchronous active-low reset
tick  in  1  one-clk-wide time-base enable, synchronous to clk
red  in  1  Red lamp from traffic-light FSM, asynchronous to clk
yellow  in  1  Yellow lamp, asynchronous to clk
green  in  1  Green lamp, asynchronous to clk
btn  in  1  raw pedestrian button, asynchronous, active-high, bouncy
walk  out  1  WALK lamp
dont_walk  out  1  DON'T-WALK lamp (toggles in FLASH)
flash  out  1  high while in FLASH
req_pending  out  1  latched pedestrian request awaiting service
countdown  out  CW  remaining ticks of the crossing window, 0 otherwise
abort  out  1  one-cycle pulse when a walk window is cut short
lamp_fault  out  1  illegal lamp code persisted ≥2 cycles

Behaviour:
- Clock and reset: one clock domain. rst_n is asynchronous assert, synchronous deassert. Reset values: walk=0, dont_walk=1, flash=0, req_pending=0, countdown=0, abort=0, lamp_fault=0, state=IDLE. All synchronisers, counters and the debouncer are cleared by reset.
- Outputs: all outputs are registered.
- Synchronisers: red, yellow, green and btn each pass through a 2-flop synchroniser, giving red_s, yellow_s, green_s and btn_s. red_d is red_s delayed one cycle. red_rise = red_s & ~red_d.
- Lamp check: a lamp code is legal when exactly one of red_s, yellow_s, green_s is high.
  - An illegal code for 1 cycle is ignored (transition skew).
  - An illegal code for 2 or more consecutive cycles sets lamp_fault=1 on the following cycle.
  - lamp_fault clears on the first cycle after a legal code is seen.
- Debouncer: counter increments while btn_s ≠ btn_db and resets to 0 when they are equal. When the count reaches DEB_CYCLES-1 with a mismatch, btn_db takes btn_s and the counter clears. Press latency from btn to btn_db is 2 + DEB_CYCLES clks.
- Request latch: a rising edge of btn_db sets req_pending on the next cycle. req_pending clears on entry to WALK only. Presses made in any other state are retained.
- FSM states: IDLE, WALK, FLASH, CLEAR.
  - IDLE: walk=0, dont_walk=1, countdown=0. If req_pending and red_rise and no fault are all true, go to WALK. A request raised mid-red waits for the next red_rise.
  - WALK: walk=1, dont_walk=0. On entry the tick counter tcnt is loaded with WALK_TICKS and countdown with WALK_TICKS+FLASH_TICKS. On each tick both decrement. A tick with tcnt==1 moves to FLASH and loads tcnt=FLASH_TICKS.
  - FLASH: walk=0, flash=1. dont_walk=1 on entry and inverts on each tick. countdown decrements on each tick. A tick with tcnt==1 moves to CLEAR.
  - CLEAR: dont_walk=1, walk=0, flash=0, countdown=0. Return to IDLE once red_s=0. Only one walk window is granted per red phase.
- Abort: in WALK or FLASH, red_s=0 or lamp_fault=1 moves to CLEAR on the next cycle and pulses abort for 1 cycle. Abort has priority over a same-cycle tick. req_pending is not re-armed by an abort.
- Fault handling: lamp_fault=1 in any state forces CLEAR-equivalent outputs and blocks entry to WALK.
- Reset mid-operation: any state returns to reset values immediately.

Test Plan:
1. Basic window: green phase, btn held high 30 clks → req_pending=1 at 2+16+1 clks after press. On red rising, walk=1 ~3 clks later with countdown=8. After 4 ticks, flash=1 and dont_walk toggles on each of the next 4 ticks. Then CLEAR with dont_walk=1 and req_pending=0.
2. Bounce rejection: btn toggles every 3 clks for 60 clks, then stays low → req_pending stays 0 and walk stays 0 through the next red.
3. Mid-red request: press completes while red is high → no WALK in this red. WALK starts on the next red rising edge.
4. Early red fall: red drops at WALK tick 2 → abort=1 for exactly 1 cycle, then walk=0, dont_walk=1, countdown=0, req_pending=0.
5. Lamp skew/fault: all lamps low for 1 cycle during Y→G → lamp_fault stays 0. red and green both high for 3 cycles during WALK → lamp_fault=1, abort pulse, CLEAR.
6. Async reset: rst_n low mid-FLASH, between clk edges → walk=0, dont_walk=1, flash=0, countdown=0 immediately. After release, FSM is in IDLE.
